// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes are pushed over a valid/ready port into a
// small FIFO and serialised LSB first on a registered, idle-high tx line.
module uart_tx_fifo #(
  parameter int DEPTH   = 8,
  parameter int PRESC_W = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     en,
  input  logic [PRESC_W-1:0]       prescale,
  input  logic [7:0]               wdata,
  input  logic                     wvalid,
  output logic                     wready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [PRESC_W-1:0]   timer_q, timer_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 can_start;

  // A full FIFO never accepts, even when a pop happens on the same edge.
  assign wready    = (level_q != FULL_LVL);
  assign push      = wvalid & wready;
  assign can_start = en & (level_q != '0);
  assign bit_end   = (timer_q == '0);

  assign tx    = tx_q;
  assign level = level_q;
  assign busy  = (state_q != S_IDLE) | (level_q != '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    presc_d   = presc_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          timer_d = presc_q;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          timer_d = presc_q;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next START so queued frames have no gap.
          if (can_start) begin
            pop = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Prescale is sampled only here, so changes take effect on the next frame.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q];
      presc_d   = prescale;
      timer_d   = prescale;
      bit_cnt_d = 3'd0;
      tx_d      = 1'b0;
      state_d   = S_START;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      timer_q   <= '0;
      presc_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      level_q   <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-level reference model predicts
// tx/busy/wready/level every cycle; scenario tasks compare the logged streams.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int LOGN  = 16384;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        en = 1'b0;
  logic [15:0] prescale = 16'd15;
  logic [7:0]  wdata = 8'h00;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        tx;
  logic        busy;
  logic [3:0]  level;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .PRESC_W(16)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .en       (en),
    .prescale (prescale),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .tx       (tx),
    .busy     (busy),
    .level    (level)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: a frame is 10 bits of (plat+1) cycles; bit index = cnt/(plat+1).
  logic [7:0] mq [$];
  logic [7:0] m_byte = 8'h00;
  int         m_cnt = 0;
  int         m_plat = 0;
  bit         m_active = 1'b0;
  int         m_push_cnt = 0;
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_wready = 1'b1;
  logic [3:0] m_level = 4'd0;

  always @(posedge HCLK or negedge HRESETn) begin
    bit do_push;
    int k;
    if (!HRESETn) begin
      mq.delete();
      m_active = 1'b0;
      m_cnt    = 0;
    end else begin
      do_push = wvalid && (mq.size() != DEPTH);
      if (m_active) begin
        m_cnt++;
        if (m_cnt == 10 * (m_plat + 1)) m_active = 1'b0;
      end
      if (!m_active && en && mq.size() != 0) begin
        m_byte   = mq.pop_front();
        m_plat   = int'(prescale);
        m_cnt    = 0;
        m_active = 1'b1;
      end
      if (do_push) begin
        mq.push_back(wdata);
        m_push_cnt++;
      end
    end
    k = m_cnt / (m_plat + 1);
    if (!m_active)   m_tx = 1'b1;
    else if (k == 0) m_tx = 1'b0;
    else if (k >= 9) m_tx = 1'b1;
    else             m_tx = m_byte[k-1];
    m_level  = 4'(mq.size());
    m_busy   = m_active || (mq.size() != 0);
    m_wready = (mq.size() != DEPTH);
  end

  // Per-cycle log of {tx,busy,wready,level} from DUT and model.
  logic [6:0] dut_log [LOGN];
  logic [6:0] mdl_log [LOGN];
  int         cyc = 0;

  always @(negedge HCLK) begin
    if (cyc < LOGN) begin
      dut_log[cyc] = {tx, busy, wready, level};
      mdl_log[cyc] = {m_tx, m_busy, m_wready, m_level};
    end
    cyc++;
  end

  task automatic drive_push(input logic [7:0] b);
    int n0;
    int t;
    n0 = m_push_cnt;
    t = 0;
    wdata  = b;
    wvalid = 1'b1;
    do begin
      @(negedge HCLK);
      t++;
    end while (m_push_cnt == n0 && t < 5000);
    wvalid = 1'b0;
    checks++;
    if (m_push_cnt == n0) begin
      errors++;
      $display("FAIL push_timeout byte %h: not accepted in %0d cycles, required acceptance", b, t);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 20000) begin
      @(negedge HCLK);
      t++;
    end
    repeat (3) @(negedge HCLK);
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", t);
    end
  endtask

  task automatic test_reset();
    int c0, mism;
    c0 = cyc;
    @(negedge HCLK);
    checks++; if (tx !== 1'b1)     begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (level !== 4'd0)  begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL reset_wready got %b want 1", wready); end
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);
    mism = -1;
    for (int c = c0 + 1; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL reset_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_reset done");
  endtask

  task automatic test_char_a();
    int c0, mism, s;
    logic [7:0] dec;
    logic stop_b;
    prescale = 16'd15;
    en = 1'b1;
    c0 = cyc;
    drive_push(8'h41);
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL a_level_after_push got %0d want 1", level); end
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL a_tx_before_pop got %b want 1", tx); end
    @(negedge HCLK);
    checks++; if (tx !== 1'b0)    begin errors++; $display("FAIL a_start_latency got %b want 0", tx); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL a_level_after_pop got %0d want 0", level); end
    wait_idle();
    s = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c][6] === 1'b0 && s < 0) s = c;
    dec = 8'h00;
    stop_b = 1'b0;
    if (s >= 0 && s + 160 < LOGN) begin
      for (int i = 0; i < 8; i++) dec[i] = dut_log[s + 16 * (i + 1) + 8][6];
      stop_b = dut_log[s + 16 * 9 + 8][6];
    end
    checks++; if (dec !== 8'h41 || stop_b !== 1'b1) begin errors++; $display("FAIL a_decode got %h stop %b want 41 stop 1", dec, stop_b); end
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL a_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_char_a: sent 0x41 decoded %h", dec);
  endtask

  task automatic test_back_to_back();
    int c0, mism, nb;
    prescale = 16'd15;
    en = 1'b1;
    c0 = cyc;
    wdata = 8'h4E; wvalid = 1'b1;
    @(negedge HCLK); wdata = 8'h35;
    @(negedge HCLK); wdata = 8'h0A;
    @(negedge HCLK); wvalid = 1'b0;
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL b2b_level got %0d want 2", level); end
    wait_idle();
    nb = 0;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c][5] === 1'b1) nb++;
    checks++; if (nb != 481) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 481", nb); end
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL b2b_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_back_to_back: 3 frames, busy %0d cycles", nb);
  endtask

  task automatic test_full_hold();
    int c0, mism, n0;
    prescale = 16'd2;
    en = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) drive_push(8'($urandom_range(0, 255)));
    checks++; if (level !== 4'd8)  begin errors++; $display("FAIL full_level got %0d want 8", level); end
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL full_wready got %b want 0", wready); end
    n0 = m_push_cnt;
    wdata = 8'hC9; wvalid = 1'b1;
    repeat (4) @(negedge HCLK);
    checks++; if (level !== 4'd8 || tx !== 1'b1) begin errors++; $display("FAIL full_hold level %0d tx %b want 8 1", level, tx); end
    en = 1'b1;
    @(negedge HCLK);
    checks++; if (level !== 4'd7) begin errors++; $display("FAIL full_pop_no_push got %0d want 7", level); end
    @(negedge HCLK);
    checks++; if (level !== 4'd8 || m_push_cnt != n0 + 1) begin errors++; $display("FAIL full_ninth_accept level %0d want 8", level); end
    wvalid = 1'b0;
    wait_idle();
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL full_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_full_hold: 9 bytes sent");
  endtask

  task automatic test_presc0();
    int c0, mism;
    logic [9:0] got, want;
    prescale = 16'd0;
    en = 1'b1;
    want = 10'b11_0100_1010;
    c0 = cyc;
    drive_push(8'hA5);
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      got[i] = tx;
    end
    checks++; if (got !== want) begin errors++; $display("FAIL p0_frame got %b want %b (bit0 rightmost)", got, want); end
    wait_idle();
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL p0_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_presc0: frame %b", got);
  endtask

  task automatic test_en_mid();
    int c0, mism;
    prescale = 16'd3;
    en = 1'b1;
    c0 = cyc;
    drive_push(8'h55);
    drive_push(8'h01);
    drive_push(8'h02);
    repeat (15) @(negedge HCLK);
    en = 1'b0;
    repeat (40) @(negedge HCLK);
    checks++; if (level !== 4'd2) begin errors++; $display("FAIL enmid_level got %0d want 2", level); end
    checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL enmid_idle tx %b busy %b want 1 1", tx, busy); end
    en = 1'b1;
    wait_idle();
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL enmid_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_en_mid: paused and resumed");
  endtask

  task automatic test_reset_mid();
    int c0, mism;
    prescale = 16'd7;
    en = 1'b1;
    drive_push(8'h3C);
    drive_push(8'h11);
    drive_push(8'h22);
    repeat (18) @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL rmid_tx got %b want 1", tx); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", level); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    c0 = cyc;
    drive_push(8'h5A);
    wait_idle();
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL rmid_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_reset_mid: recovered, sent 0x5A");
  endtask

  task automatic test_random();
    int c0, mism;
    c0 = cyc;
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      prescale = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) en = ~en;
      if (mq.size() == DEPTH) en = 1'b1;
      repeat ($urandom_range(0, 3)) @(negedge HCLK);
      if ($urandom_range(0, 1) == 1) begin
        wvalid = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge HCLK);
        if (mq.size() == DEPTH) en = 1'b1;
      end
      drive_push(8'($urandom_range(0, 255)));
    end
    en = 1'b1;
    wait_idle();
    mism = -1;
    for (int c = c0; c < cyc && c < LOGN; c++) if (dut_log[c] !== mdl_log[c] && mism < 0) mism = c;
    checks++;
    if (mism >= 0) begin errors++; $display("FAIL rand_stream cycle %0d got %b want %b", mism, dut_log[mism], mdl_log[mism]); end
    $display("test_random: 30 bytes over %0d cycles", cyc - c0);
  endtask

  initial begin
    repeat (3) @(negedge HCLK);
    test_reset();
    test_char_a();
    test_back_to_back();
    test_full_hold();
    test_presc0();
    test_en_mid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
